// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use / RAW hazard detection and forwarding-select generation.
// Define ID_EX_FWD_EN to compile in EX/MEM forwarding; otherwise every RAW hazard stalls.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic [31:0] id_rd1,
    input  logic [31:0] id_rd2,
    input  logic [31:0] id_imm,
    input  logic        id_regwrite,
    input  logic        id_memwrite,
    input  logic        id_memread,
    input  logic        id_alusrc,
    input  logic        id_is_jump,
    input  logic        id_has_rs2,
    input  logic        id_without_rs,
    input  logic [4:0]  id_aluop,
    input  logic [1:0]  id_wdsel,
    input  logic [2:0]  id_dmtype,
    input  logic [7:0]  id_jump_type,
    input  logic        ex_redirect,
    input  logic        mem_regwrite,
    input  logic [4:0]  mem_rd,
    output logic        stall,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [4:0]  ex_rs1,
    output logic [4:0]  ex_rs2,
    output logic [4:0]  ex_rd,
    output logic [31:0] ex_rd1,
    output logic [31:0] ex_rd2,
    output logic [31:0] ex_imm,
    output logic        ex_regwrite,
    output logic        ex_memwrite,
    output logic        ex_memread,
    output logic        ex_alusrc,
    output logic        ex_is_jump,
    output logic [4:0]  ex_aluop,
    output logic [1:0]  ex_wdsel,
    output logic [2:0]  ex_dmtype,
    output logic [7:0]  ex_jump_type,
    output logic [1:0]  ex_fwd_a,
    output logic [1:0]  ex_fwd_b,
    output logic [15:0] stall_cycles
);

    logic       use1, use2;
    logic       hit_e1, hit_e2, hit_m1, hit_m2;
    logic       hazard;
    logic [1:0] fwd_a_d, fwd_b_d;

    always_comb begin
        use1   = id_valid & ~id_without_rs & (id_rs1 != 5'd0);
        use2   = id_valid & id_has_rs2 & (id_rs2 != 5'd0);
        hit_e1 = ex_valid & ex_regwrite & (ex_rd != 5'd0) & (ex_rd == id_rs1) & use1;
        hit_e2 = ex_valid & ex_regwrite & (ex_rd != 5'd0) & (ex_rd == id_rs2) & use2;
        hit_m1 = mem_regwrite & (mem_rd != 5'd0) & (mem_rd == id_rs1) & use1;
        hit_m2 = mem_regwrite & (mem_rd != 5'd0) & (mem_rd == id_rs2) & use2;
`ifdef ID_EX_FWD_EN
        hazard = ~ex_redirect & ex_memread & (hit_e1 | hit_e2);
        // A load still in EX has no result yet, so only an ALU producer forwards from EX/MEM.
        fwd_a_d = (hit_e1 & ~ex_memread) ? 2'b01 : (hit_m1 ? 2'b10 : 2'b00);
        fwd_b_d = (hit_e2 & ~ex_memread) ? 2'b01 : (hit_m2 ? 2'b10 : 2'b00);
`else
        hazard  = ~ex_redirect & (hit_e1 | hit_e2 | hit_m1 | hit_m2);
        fwd_a_d = 2'b00;
        fwd_b_d = 2'b00;
`endif
        stall = hazard;
    end

    always_ff @(posedge clk) begin
        if (rst || ex_redirect || hazard) begin
            ex_valid     <= 1'b0;
            ex_pc        <= '0;
            ex_rs1       <= '0;
            ex_rs2       <= '0;
            ex_rd        <= '0;
            ex_rd1       <= '0;
            ex_rd2       <= '0;
            ex_imm       <= '0;
            ex_regwrite  <= 1'b0;
            ex_memwrite  <= 1'b0;
            ex_memread   <= 1'b0;
            ex_alusrc    <= 1'b0;
            ex_is_jump   <= 1'b0;
            ex_aluop     <= '0;
            ex_wdsel     <= '0;
            ex_dmtype    <= '0;
            ex_jump_type <= '0;
            ex_fwd_a     <= 2'b00;
            ex_fwd_b     <= 2'b00;
        end else begin
            ex_valid     <= id_valid;
            ex_pc        <= id_pc;
            ex_rs1       <= id_rs1;
            ex_rs2       <= id_rs2;
            ex_rd        <= id_rd;
            ex_rd1       <= id_rd1;
            ex_rd2       <= id_rd2;
            ex_imm       <= id_imm;
            ex_regwrite  <= id_regwrite;
            ex_memwrite  <= id_memwrite;
            ex_memread   <= id_memread;
            ex_alusrc    <= id_alusrc;
            ex_is_jump   <= id_is_jump;
            ex_aluop     <= id_aluop;
            ex_wdsel     <= id_wdsel;
            ex_dmtype    <= id_dmtype;
            ex_jump_type <= id_jump_type;
            ex_fwd_a     <= fwd_a_d;
            ex_fwd_b     <= fwd_b_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (hazard && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end

endmodule
